// File: rtl/sseg_pkg.sv
// Shared types, constants and helpers for the seven-segment scan driver.
package sseg_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    localparam logic [7:0] SSEG_OFF = 8'hFF;
    // Wide enough for the largest bank; the top slices it to N_DIGITS.
    localparam logic [7:0] AN_OFF   = 8'hFF;

    // True on the last count of the current phase of a slot.
    function automatic logic slot_last(input int cnt, input state_t state,
                                       input int blank_ticks, input int digit_ticks);
        if (state == S_BLANK)
            return cnt == blank_ticks - 1;
        else
            return cnt == digit_ticks - blank_ticks - 1;
    endfunction

endpackage

// File: rtl/Hex2Sseg.sv
// Hex digit to active-low seven-segment decoder, output {dp, a..g}.
module Hex2Sseg (
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    logic [6:0] seg;

    // Segment pattern lookup, a in bit 6 down to g in bit 0, 0 = lit.
    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
    end

    assign sseg = {dp, seg};

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed common-anode display scanner with double-buffered
// digit/dp/blank data, per-slot blank dead time and a frame pulse.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS    = 3,
    parameter int DIGIT_TICKS = 12000,
    parameter int BLANK_TICKS = 600
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] hex_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  load,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    localparam int CW = $clog2(DIGIT_TICKS);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = 6 * N_DIGITS;
    // Buffer layout: [4N-1:0] hex, [5N-1:4N] dp-lit flags, [6N-1:5N] blank.
    localparam int DP_LSB = 4 * N_DIGITS;
    localparam int BL_LSB = 5 * N_DIGITS;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic            last, boundary;
    logic [BW-1:0]   pend, disp;
    logic            pend_valid;
    logic            wrap_q;
    logic [3:0]      cur_hex;
    logic            cur_dp, cur_blank;
    logic [7:0]      dec_sseg;

    // Slot sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
        end
    end

    // Next-state: blank window, then on window, then advance the slot.
    always_comb begin
        last     = slot_last(32'(cnt), state, BLANK_TICKS, DIGIT_TICKS);
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        boundary = 1'b0;
        case (state)
            S_BLANK: begin
                if (last) begin
                    state_nx = S_ON;
                    cnt_nx   = '0;
                end
            end
            S_ON: begin
                if (last) begin
                    state_nx = S_BLANK;
                    cnt_nx   = '0;
                    if (idx == IW'(N_DIGITS - 1)) begin
                        idx_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_BLANK;
                cnt_nx   = '0;
            end
        endcase
    end

    // Double buffer: the display copy only moves at a frame boundary so a
    // frame never mixes old and new digits. The dp is stored as a "lit" flag
    // (inverted) so a cleared buffer shows a dark decimal point.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend       <= '0;
            disp       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                disp       <= pend;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend       <= {blank_in, ~dp_in, hex_in};
                pend_valid <= 1'b1;
            end
        end
    end

    assign cur_hex   = disp[4*idx +: 4];
    assign cur_dp    = ~disp[DP_LSB + idx];
    assign cur_blank = disp[BL_LSB + idx];

    Hex2Sseg u_dec (
        .hex  (cur_hex),
        .dp   (cur_dp),
        .sseg (dec_sseg)
    );

    // Output registers. frame_tick is delayed one extra stage so it lines up
    // with the registered an/sseg stream and lands in the first blank cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an         <= AN_OFF[N_DIGITS-1:0];
            sseg       <= SSEG_OFF;
            wrap_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            wrap_q     <= boundary;
            frame_tick <= wrap_q;
            if (state == S_ON && !cur_blank) begin
                an   <= ~(N_DIGITS'(1) << idx);
                sseg <= dec_sseg;
            end else begin
                an   <= AN_OFF[N_DIGITS-1:0];
                sseg <= SSEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux: frame-position model plus directed scenarios.
module tb_sseg_scan_mux;

    localparam int N  = 3;
    localparam int DT = 8;
    localparam int BT = 2;
    localparam int F  = N * DT;

    logic          clk;
    logic          reset_n;
    logic [11:0]   hex_in;
    logic [2:0]    dp_in;
    logic [2:0]    blank_in;
    logic          load;
    logic [2:0]    an;
    logic [7:0]    sseg;
    logic          frame_tick;

    int checks = 0;
    int errors = 0;

    sseg_scan_mux #(.N_DIGITS(N), .DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hex_in     (hex_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyphs, {dp, a..g}, active low.
    function automatic logic [7:0] seg7(input logic [3:0] h, input logic dp);
        logic [6:0] p;
        case (h)
            4'h0: p = 7'b0000001;  4'h1: p = 7'b1001111;
            4'h2: p = 7'b0010010;  4'h3: p = 7'b0000110;
            4'h4: p = 7'b1001100;  4'h5: p = 7'b0100100;
            4'h6: p = 7'b0100000;  4'h7: p = 7'b0001111;
            4'h8: p = 7'b0000000;  4'h9: p = 7'b0000100;
            4'hA: p = 7'b0001000;  4'hB: p = 7'b1100000;
            4'hC: p = 7'b0110001;  4'hD: p = 7'b1000010;
            4'hE: p = 7'b0110000;  default: p = 7'b0111000;
        endcase
        return {dp, p};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: output at edge t (t = edges since reset release) is fixed by the
    // frame position t mod F and the displayed data, which swaps in the pending
    // data on the last edge of every frame.
    int         t;
    bit         mvalid = 1'b0;
    logic [11:0] m_hex, p_hex;
    logic [2:0]  m_dp, p_dp, m_bl, p_bl;
    bit          m_pv;
    logic [2:0]  exp_an;
    logic [7:0]  exp_sseg;
    logic        exp_ft;

    always @(posedge clk) begin
        int slot, ofs;
        if (!reset_n) begin
            t = 0;
            m_hex = '0; m_dp = 3'b111; m_bl = '0;
            p_hex = '0; p_dp = 3'b111; p_bl = '0;
            m_pv = 1'b0;
            exp_an = 3'b111; exp_sseg = 8'hFF; exp_ft = 1'b0;
        end else begin
            slot = (t / DT) % N;
            ofs  = t % DT;
            exp_ft = (t > 0) && (t % F == 0);
            if (ofs >= BT && !m_bl[slot]) begin
                exp_an = 3'b111;
                exp_an[slot] = 1'b0;
                exp_sseg = seg7(m_hex[slot*4 +: 4], m_dp[slot]);
            end else begin
                exp_an = 3'b111;
                exp_sseg = 8'hFF;
            end
            if (t % F == F - 1 && m_pv) begin
                m_hex = p_hex; m_dp = p_dp; m_bl = p_bl;
                m_pv = 1'b0;
            end
            if (load) begin
                p_hex = hex_in; p_dp = dp_in; p_bl = blank_in;
                m_pv = 1'b1;
            end
            t++;
        end
        mvalid = 1'b1;
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_an", int'(an), int'(exp_an));
            chk("model_sseg", int'(sseg), int'(exp_sseg));
            chk("model_frame_tick", int'(frame_tick), int'(exp_ft));
        end
    end

    task automatic tick_wait();
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (frame_tick) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_tick: no pulse within 100 cycles");
        end
    endtask

    // Called right after reset release: first lit edge must be BT edges in.
    task automatic first_on(input string nm);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (an != 3'b111) seen = 1'b1;
        end
        chk({nm, "_latency"}, n - 1, BT);
        chk({nm, "_an"}, int'(an), 3'b110);
        chk({nm, "_sseg"}, int'(sseg), 8'h81);
    endtask

    // Starting on the frame_tick cycle, scan one frame and collect per-slot data.
    int low[3];
    int dark[3];
    logic [7:0] s[3];
    task automatic scan_frame();
        for (int k = 0; k < 3; k++) begin low[k] = 0; dark[k] = 0; s[k] = 8'h00; end
        for (int i = 0; i < F; i++) begin
            int sl;
            if (i > 0) @(negedge clk);
            sl = i / DT;
            if (an != 3'b111) low[sl]++;
            if (an == 3'b111 && sseg == 8'hFF) dark[sl]++;
            if (i % DT == BT) s[sl] = sseg;
        end
    endtask

    task automatic do_load(input logic [11:0] h, input logic [2:0] d, input logic [2:0] b);
        hex_in = h; dp_in = d; blank_in = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int last_t, n;
        reset_n = 1'b0; load = 1'b0;
        hex_in = '0; dp_in = 3'b111; blank_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_an", int'(an), 3'b111);
        chk("reset_sseg", int'(sseg), 8'hFF);
        reset_n = 1'b1;
        first_on("rst");

        // Load then scan.
        do_load(12'h3A7, 3'b101, 3'b000);
        tick_wait();
        scan_frame();
        chk("scan_s0", int'(s[0]), 8'h8F);
        chk("scan_s1", int'(s[1]), 8'h08);
        chk("scan_s2", int'(s[2]), 8'h86);
        for (int k = 0; k < 3; k++) chk("scan_low", low[k], DT - BT);

        // Blanked middle digit.
        do_load(12'h3A7, 3'b101, 3'b010);
        tick_wait();
        scan_frame();
        chk("blank_s0", int'(s[0]), 8'h8F);
        chk("blank_s2", int'(s[2]), 8'h86);
        chk("blank_low0", low[0], DT - BT);
        chk("blank_dark1", dark[1], DT);
        chk("blank_low2", low[2], DT - BT);

        // Load on the boundary edge: old pending shows first.
        tick_wait();
        do_load(12'h123, 3'b111, 3'b000);
        repeat (F - 3) @(negedge clk);
        do_load(12'h456, 3'b111, 3'b000);
        tick_wait();
        scan_frame();
        chk("coinc_old_s0", int'(s[0]), 8'h86);
        chk("coinc_old_s1", int'(s[1]), 8'h92);
        chk("coinc_old_s2", int'(s[2]), 8'hCF);
        chk("coinc_old_low1", low[1], DT - BT);
        tick_wait();
        scan_frame();
        chk("coinc_new_s0", int'(s[0]), 8'hA0);
        chk("coinc_new_s1", int'(s[1]), 8'hA4);
        chk("coinc_new_s2", int'(s[2]), 8'hCC);

        // Reset during slot 2 on-time, with a load pending.
        tick_wait();
        repeat (18) @(negedge clk);
        do_load(12'hFFF, 3'b000, 3'b000);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_an", int'(an), 3'b111);
        chk("midrst_sseg", int'(sseg), 8'hFF);
        reset_n = 1'b1;
        first_on("midrst");
        tick_wait();
        scan_frame();
        chk("midrst_s0", int'(s[0]), 8'h81);
        chk("midrst_s1", int'(s[1]), 8'h81);
        chk("midrst_s2", int'(s[2]), 8'h81);

        // Frame tick cadence over 5 frames.
        tick_wait();
        for (int f = 0; f < 5; f++) begin
            n = 0;
            last_t = 0;
            while (n < 100 && last_t == 0) begin
                @(negedge clk);
                n++;
                if (frame_tick) last_t = n;
            end
            chk("tick_period", last_t, F);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
